uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among N_REQ byte sources (key scanner, status reporter, debug). It grants one requester at a time and latches its byte. It then sequences the transmitter's edge-triggered start (uart_en / uart_din) and waits on the transmitter's busy flag (tx_flag) before the next grant. It sits between the requesters and the transmitter, so requesters never see transmitter timing.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- GAP_CYC, 2: idle cycles forced after tx_flag falls, ≥2.
- START_TO, 8: cycles allowed in START for tx_flag to rise before timeout, ≥4.
- sys_clk  in  1  system clock; the only clock.
- sys_rst  in  1  reset; asynchronous, active-high.
- req  in  N_REQ  per-requester level request; held until its ack.
- req_data  in  8*N_REQ  byte for requester i at [8i+7:8i]; stable while req[i] high.
- ack  out  N_REQ  one-cycle pulse: byte of requester i accepted; requester may drop or re-arm req next cycle.
- uart_en  out  1  transmitter start; rising edge starts a frame.
- uart_din  out  8  byte to the transmitter; held from grant until return to IDLE.
- tx_flag  in  1  transmitter busy flag.
- busy  out  1  high in every state except IDLE.
- grant_id  out  max(1,$clog2(N_REQ))  index of the current or last granted requester.
- timeout_err  out  1  one-cycle pulse when START times out.

## Operation
- Reset values: state IDLE, ack=0, uart_en=0, uart_din=0, busy=0, grant_id=0, timeout_err=0, rr pointer=N_REQ-1 (requester 0 has priority first), counters 0.
- FSM states: IDLE, START, WAIT_DONE, GAP.
- IDLE: when req≠0, pick the first set bit searching ptr+1, ptr+2, … mod N_REQ. Then:
  - latch req_data slice into uart_din;
  - set grant_id and ptr to the winner;
  - pulse ack[winner];
  - go to START.
- START: uart_en=1, counter increments each cycle.
  - tx_flag=1 → uart_en=0, go to WAIT_DONE.
  - counter reaches START_TO-1 with tx_flag still 0 → uart_en=0, pulse timeout_err, go to GAP. The byte is dropped; the requester is not re-acked.
- WAIT_DONE: uart_en=0; on tx_flag=0 go to GAP. No timeout here (frame length is set by the baud rate).
- GAP: count GAP_CYC cycles with uart_en=0, then go to IDLE. This guarantees uart_en is low for ≥2 cycles so the transmitter's edge detector re-arms.
- Only one ack is ever high at a time. Requests arriving outside IDLE wait; req is never dropped by the arbiter.
- A requester that keeps req high after ack is queued for a new byte. Fairness: after requester i is served, all others requesting are served before i again.
- The transmitter's own reset is driven separately; the arbiter makes no assumption about it beyond tx_flag=0 after reset.

## Timing
- req[i] sampled high in IDLE at edge t:
  - t+1: state START, uart_en=1, uart_din valid, ack[i]=1, busy=1.
  - t+2: ack=0.
- Transmitter raises tx_flag 3 cycles after the uart_en rise. uart_en is therefore high 4 cycles (START exits the cycle after tx_flag is seen).
- tx_flag falls at edge f: GAP from f+1. IDLE re-entered at f+1+GAP_CYC; the next grant's ack appears one cycle later.
- Per-byte overhead beyond the transmitter's frame: ≈ 3 + GAP_CYC + 2 cycles.
- uart_din changes only on a grant; it holds its value through GAP and IDLE.
- sys_rst asserted mid-frame: all outputs return to reset values immediately (asynchronous). The in-flight byte is abandoned and no ack is re-issued.
- Simultaneous req from all requesters with ptr=N_REQ-1: grant order 0,1,2,3,0,…

## Test plan
- Single request: req=4'b0010, req_data[15:8]=8'hA5, transmitter model raises tx_flag 3 cycles after uart_en.
  - Expect ack=4'b0010 for exactly 1 cycle and uart_din=8'hA5.
  - Expect uart_en high 4 cycles, grant_id=1.
  - Expect return to IDLE GAP_CYC cycles after tx_flag falls.
- Round-robin: req=4'b1111 held, bytes 8'h10/8'h11/8'h12/8'h13. Expect ack order 0,1,2,3,0 and uart_din 8'h10,8'h11,8'h12,8'h13,8'h10.
- Timeout: tx_flag stuck 0, req=4'b0001.
  - Expect timeout_err pulse 8 cycles after the uart_en rise, uart_en=0, then GAP then IDLE.
  - With req still high, expect a second ack.
- Edge re-arm: back-to-back bytes. Check uart_en low ≥2 consecutive cycles between every pair of rises, and no uart_en rise while tx_flag=1.
- Reset mid-frame: assert sys_rst during WAIT_DONE.
  - Expect all outputs at reset values asynchronously.
  - After release with req=4'b0100, expect the first grant to go to requester 2.
- Late request: req[3] rises during WAIT_DONE of requester 0. Expect ack[3] only after GAP; no ack pulses during WAIT_DONE.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter: grant -> START (uart_en) -> WAIT_DONE -> GAP -> IDLE.
// ack one cycle after grant; requests outside IDLE simply wait (req held by source until ack).
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int GAP_CYC  = 2,
  parameter int START_TO = 8,
  localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               uart_en,
  output logic [7:0]         uart_din,
  input  logic               tx_flag,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               timeout_err
);

  localparam int CMAX = (START_TO > GAP_CYC) ? START_TO : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    gid_q, gid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       din_q, din_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             en_q, en_d;
  logic             to_q, to_d;

  logic             win_vld;
  logic [GW-1:0]    win_idx;
  logic [7:0]       win_byte;

  // Search starts just after the last winner, wrapping modulo N_REQ.
  always_comb begin : pick
    logic [GW:0]   sum;
    logic [GW-1:0] cand;
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (GW+1)'(k);
      if (sum >= (GW+1)'(N_REQ)) sum = sum - (GW+1)'(N_REQ);
      cand = sum[GW-1:0];
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GW'(i) == win_idx) win_byte = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    ack_d   = '0;
    to_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          din_d          = win_byte;
          ptr_d          = win_idx;
          gid_d          = win_idx;
          ack_d[win_idx] = 1'b1;
          cnt_d          = '0;
          state_d        = S_START;
        end
      end
      S_START: begin
        if (tx_flag) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(START_TO - 1)) begin
          // Transmitter never answered: drop the byte, no re-ack.
          to_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_flag) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    en_d = (state_d == S_START);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= GW'(N_REQ - 1);
      gid_q   <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      ack_q   <= '0;
      en_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      to_q    <= to_d;
    end
  end

  assign ack         = ack_q;
  assign uart_en     = en_q;
  assign uart_din    = din_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = gid_q;
  assign timeout_err = to_q;

endmodule
